// File: rtl/systema_btn_svc.sv
// Button PIO service: writes the IRQ mask once, then reads/clears edge capture on irq or poll and reports events.
// Latency: leaving IDLE to the clear write is 3 cycles; event record and counters update at the end of the clear cycle.
// Backpressure: an unaccepted event absorbs later captures by OR-merge and raises evt_ovf; the bus side never stalls.
module systema_btn_svc #(
  parameter logic [1:0]  IRQ_MASK    = 2'b11,
  parameter int unsigned POLL_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        irq,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_bits,
  output logic        evt_ovf,
  output logic [1:0]  btn_level,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_CLR
  } state_t;

  localparam logic [31:0] POLL_LAST = (POLL_CYCLES == 0) ? 32'd0 : 32'(POLL_CYCLES - 1);

  state_t      state;
  logic [31:0] timer;
  logic [1:0]  cap;

  // Only the two button bits of the PIO data path carry meaning.
  logic unused_rd;
  assign unused_rd = ^readdata[31:2];

  // Single FSM: registered bus outputs always describe the current state's bus cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_INIT;
      address    <= 2'd0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= 32'd0;
      evt_valid  <= 1'b0;
      evt_bits   <= 2'b00;
      evt_ovf    <= 1'b0;
      btn_level  <= 2'b00;
      cnt0       <= 16'd0;
      cnt1       <= 16'd0;
      timer      <= 32'd0;
      cap        <= 2'b00;
    end else begin
      // Consumer handshake retires the record; a clear cycle below takes precedence.
      if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
        evt_bits  <= 2'b00;
        evt_ovf   <= 1'b0;
      end

      case (state)
        S_INIT: begin
          // Reset leaves the bus idle, so the first INIT cycle sets up the mask
          // write and the next one (chipselect already high) retires it.
          if (!chipselect) begin
            address    <= 2'd2;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            writedata  <= {30'd0, IRQ_MASK};
          end else begin
            state      <= S_IDLE;
            address    <= 2'd0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= 32'd0;
          end
        end

        S_IDLE: begin
          btn_level <= readdata[1:0];
          timer     <= timer + 32'd1;
          if (irq || (POLL_CYCLES != 0 && timer == POLL_LAST)) begin
            timer      <= 32'd0;
            state      <= S_RD_ADDR;
            address    <= 2'd3;
            chipselect <= 1'b1;
            write_n    <= 1'b1;
          end
        end

        S_RD_ADDR: begin
          state <= S_RD_DATA;
        end

        S_RD_DATA: begin
          cap <= readdata[1:0];
          if (readdata[1:0] != 2'b00) begin
            state     <= S_CLR;
            write_n   <= 1'b0;
            writedata <= 32'h3;
          end else begin
            state      <= S_IDLE;
            address    <= 2'd0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
          end
        end

        S_CLR: begin
          cnt0 <= cnt0 + {15'd0, cap[0]};
          cnt1 <= cnt1 + {15'd0, cap[1]};
          if (!evt_valid || evt_ready) begin
            evt_bits  <= cap;
            evt_valid <= 1'b1;
            evt_ovf   <= 1'b0;
          end else begin
            evt_bits  <= evt_bits | cap;
            evt_valid <= 1'b1;
            evt_ovf   <= 1'b1;
          end
          state      <= S_IDLE;
          address    <= 2'd0;
          chipselect <= 1'b0;
          write_n    <= 1'b1;
          writedata  <= 32'd0;
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: doc/systema_btn_svc.md
SYSTEMA_BTN_SVC -- requirements
Module: systema_btn_svc

Interface
REQ-001 Parameter IRQ_MASK, default 2'b11: value written to the button PIO interrupt-mask register at init.
REQ-002 Parameter POLL_CYCLES, default 50000: idle cycles between unsolicited polls; 0 disables polling.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 address  out  2  Avalon-MM address to button PIO.
REQ-006 chipselect  out  1  Avalon-MM select.
REQ-007 write_n  out  1  active-low write strobe.
REQ-008 writedata  out  32  write data.
REQ-009 readdata  in  32  PIO read data; registered every cycle from address, so valid exactly one cycle after address is driven; only bits [1:0] used.
REQ-010 irq  in  1  PIO level interrupt.
REQ-011 evt_valid  out  1  event record pending.
REQ-012 evt_ready  in  1  consumer accepts record when evt_valid=1.
REQ-013 evt_bits  out  2  buttons that produced a rising edge since last accepted record.
REQ-014 evt_ovf  out  1  new capture merged while a record was pending.
REQ-015 btn_level  out  2  last sampled button levels.
REQ-016 cnt0, cnt1  out  16 each  per-button rising-edge totals.

Function
REQ-017 FSM states: INIT, IDLE, RD_ADDR, RD_DATA, CLR; exactly one state per cycle.
REQ-018 INIT: drive address=2, chipselect=1, write_n=0, writedata={30'b0,IRQ_MASK} for one cycle, then IDLE.
REQ-019 IDLE: address=0, chipselect=0, write_n=1, writedata=0; btn_level <= readdata[1:0] every IDLE cycle.
REQ-020 IDLE poll timer increments each IDLE cycle; leave IDLE for RD_ADDR when irq=1 or (POLL_CYCLES!=0 and timer==POLL_CYCLES-1); timer clears on leaving IDLE.
REQ-021 RD_ADDR: address=3, chipselect=1, write_n=1; one cycle, then RD_DATA.
REQ-022 RD_DATA: address=3 held; cap <= readdata[1:0] at end of cycle; next state CLR if readdata[1:0]!=0, else IDLE.
REQ-023 CLR: address=3, chipselect=1, write_n=0, writedata=32'h3 for one cycle, then IDLE; poll-to-clear latency 3 cycles.
REQ-024 In the CLR cycle, for each set bit of cap: corresponding cntN increments by 1, wrapping 16'hFFFF->0.
REQ-025 In the CLR cycle: if evt_valid=0 or evt_ready=1, evt_bits <= cap and evt_valid <= 1; else evt_bits <= evt_bits | cap and evt_ovf <= 1.
REQ-026 Handshake: evt_valid && evt_ready outside a CLR merge clears evt_valid, evt_bits and evt_ovf next cycle.
REQ-027 evt_valid, evt_bits stable while evt_valid=1 and evt_ready=0, except OR-merge per REQ-025.
REQ-028 Edges arriving at the PIO after the RD_DATA sample and before the CLR write are discarded by the PIO clear; accepted limitation.
REQ-029 irq held high with empty capture: sequence IDLE->RD_ADDR->RD_DATA->IDLE repeats, no event, no counter change.

Reset
REQ-030 reset_n=0 forces immediately: state INIT, chipselect=0, write_n=1, address=0, writedata=0, evt_valid=0, evt_bits=0, evt_ovf=0, btn_level=0, cnt0=cnt1=0, timer=0, cap=0.
REQ-031 Reset asserted mid-transaction aborts it; after release INIT re-runs before any other access.

Verification
REQ-032 Release reset -> first bus cycle address=2, write_n=0, writedata=3; then IDLE with chipselect=0.
REQ-033 PIO model edge_capture=2'b01, irq=1 -> read addr 3, write 32'h3 to addr 3 three cycles after leaving IDLE; evt_bits=01, evt_valid=1, cnt0=1, cnt1=0.
REQ-034 irq=0, POLL_CYCLES=8, edge_capture=2'b10 -> read starts after 8 IDLE cycles; evt_bits=10, cnt1=1.
REQ-035 evt_ready=0, two captures 01 then 10 -> evt_bits=11, evt_ovf=1; evt_ready=1 one cycle -> evt_valid=0, evt_ovf=0.
REQ-036 cnt0 preloaded via 65535 edges -> next edge gives cnt0=0.
REQ-037 reset_n pulsed low during RD_DATA -> outputs at reset values same cycle; INIT write repeated after release; no CLR write issued.
